// File: rtl/config_chain_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package config_chain_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} cc_state_t;

    // Width of a counter that must hold every value from 0 up to n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cc_word_serializer.sv
// Parallel-load, right-shift word register with an in-word bit counter.
module cc_word_serializer
    import config_chain_pkg::*;
#(
    parameter int unsigned WORD_W = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data_in,
    output logic              bit_out,
    output logic              last_bit
);

    localparam int unsigned CntW = cnt_w(WORD_W);
    localparam logic [CntW-1:0] LastIdx = CntW'(WORD_W - 1);

    logic [WORD_W-1:0] sreg_q;
    logic [CntW-1:0]   cnt_q;

    always_ff @(posedge CK) begin
        if (RST) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sreg_q <= data_in;
            cnt_q  <= '0;
        end else if (shift) begin
            sreg_q <= sreg_q >> 1;
            cnt_q  <= cnt_q + CntW'(1);
        end
    end

    assign bit_out  = sreg_q[0];
    assign last_bit = (cnt_q == LastIdx);

endmodule

// File: rtl/config_chain_loader.sv
// Streams configuration words into the scan chain head and releases I/O isolation once
// exactly CHAIN_LEN bits have been shifted.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              cc_head,
    output logic              cc_se,
    output logic              busy,
    output logic              done,
    output logic              io_isol_n
);

    localparam int unsigned TotW = cnt_w(CHAIN_LEN);
    localparam logic [TotW-1:0] LastIdx = TotW'(CHAIN_LEN - 1);

    cc_state_t       state_q;
    logic [TotW-1:0] total_q;
    logic            head_hold_q;
    logic            ser_load;
    logic            ser_bit;
    logic            ser_last;

    // word_ready is a registered copy of "in LOAD", so this never looks at a stale state.
    assign ser_load = word_ready && word_valid;

    cc_word_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .CK      (CK),
        .RST     (RST),
        .load    (ser_load),
        .shift   (cc_se),
        .data_in (word_data),
        .bit_out (ser_bit),
        .last_bit(ser_last)
    );

    // Chain head follows the shifting bit, and keeps the last shifted bit while idle.
    assign cc_head = cc_se ? ser_bit : head_hold_q;

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= IDLE;
            total_q     <= '0;
            head_hold_q <= 1'b0;
            word_ready  <= 1'b0;
            cc_se       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            io_isol_n   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        total_q    <= '0;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        io_isol_n  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ser_load) begin
                        state_q    <= SHIFT;
                        word_ready <= 1'b0;
                        cc_se      <= 1'b1;
                    end
                end
                SHIFT: begin
                    head_hold_q <= ser_bit;
                    total_q     <= total_q + TotW'(1);
                    if (total_q == LastIdx) begin
                        // Any unshifted bits of this word are simply left behind.
                        state_q   <= DONE;
                        cc_se     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        io_isol_n <= 1'b1;
                    end else if (ser_last) begin
                        state_q    <= LOAD;
                        cc_se      <= 1'b0;
                        word_ready <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a bit-level scoreboard on cc_head.
module tb_config_chain_loader;
    import config_chain_pkg::*;

    logic       CK = 1'b0;
    logic       RST;
    logic [2:0] start_v;
    logic [2:0] valid_v;
    logic [7:0] wdata;
    logic [2:0] ready_v, head_v, se_v, busy_v, done_v, isol_v;

    int total_n = 0;
    int bad_n   = 0;
    int sel     = 0;
    int cyc     = 0;
    int shifts  = 0;
    int pushed  = 0;
    int last_shift_cyc = 0;
    logic exp_q[$];
    int chain_len[3] = '{10, 8, 1};
    int word_w[3]    = '{4, 4, 8};

    always #5 CK = ~CK;

    config_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_a (
        .CK(CK), .RST(RST), .start(start_v[0]), .word_valid(valid_v[0]),
        .word_data(wdata[3:0]), .word_ready(ready_v[0]), .cc_head(head_v[0]),
        .cc_se(se_v[0]), .busy(busy_v[0]), .done(done_v[0]), .io_isol_n(isol_v[0])
    );

    config_chain_loader #(.CHAIN_LEN(8), .WORD_W(4)) u_b (
        .CK(CK), .RST(RST), .start(start_v[1]), .word_valid(valid_v[1]),
        .word_data(wdata[3:0]), .word_ready(ready_v[1]), .cc_head(head_v[1]),
        .cc_se(se_v[1]), .busy(busy_v[1]), .done(done_v[1]), .io_isol_n(isol_v[1])
    );

    config_chain_loader #(.CHAIN_LEN(1), .WORD_W(8)) u_c (
        .CK(CK), .RST(RST), .start(start_v[2]), .word_valid(valid_v[2]),
        .word_data(wdata), .word_ready(ready_v[2]), .cc_head(head_v[2]),
        .cc_se(se_v[2]), .busy(busy_v[2]), .done(done_v[2]), .io_isol_n(isol_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge, and score any shifted bit.
    task automatic tick();
        logic e;
        @(posedge CK);
        #1;
        cyc++;
        if (se_v[sel]) begin
            shifts++;
            last_shift_cyc = cyc;
            check("shift_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("head_bit", 32'(head_v[sel]), 32'(e));
            end
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        int nb;
        nb = word_w[sel];
        if (chain_len[sel] - pushed < nb) nb = chain_len[sel] - pushed;
        for (int i = 0; i < nb; i++) exp_q.push_back(w[i]);
        pushed += nb;
    endtask

    task automatic begin_load();
        pushed = 0;
        shifts = 0;
        exp_q.delete();
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
        check("start_busy", 32'(busy_v[sel]), 32'd1);
        check("start_ready", 32'(ready_v[sel]), 32'd1);
        check("start_done_clr", 32'(done_v[sel]), 32'd0);
        check("start_isol", 32'(isol_v[sel]), 32'd0);
    endtask

    task automatic send_word(input logic [7:0] w, input bit mid_start);
        bit acc;
        bit rdy;
        acc = 1'b0;
        wdata = w;
        valid_v[sel] = 1'b1;
        push_word(w);
        for (int k = 0; k < 40 && !acc; k++) begin
            rdy = ready_v[sel];
            tick();
            acc = rdy;
        end
        check("word_accepted", 32'(acc), 32'd1);
        check("se_after_accept", 32'(se_v[sel]), 32'd1);
        if (mid_start) begin
            start_v[sel] = 1'b1;
            tick();
            start_v[sel] = 1'b0;
            check("mid_start_busy", 32'(busy_v[sel]), 32'd1);
            check("mid_start_se", 32'(se_v[sel]), 32'd1);
        end
    endtask

    task automatic gap(input int n);
        valid_v[sel] = 1'b0;
        repeat (n) tick();
        check("gap_se_low", 32'(se_v[sel]), 32'd0);
        check("gap_ready", 32'(ready_v[sel]), 32'd1);
    endtask

    // Hold a spare valid word until done; none of it may be taken.
    task automatic finish_load(input logic exp_head);
        int extra;
        bit rdy;
        bit fin;
        extra = 0;
        fin = 1'b0;
        wdata = 8'hFF;
        valid_v[sel] = 1'b1;
        for (int k = 0; k < 60 && !fin; k++) begin
            rdy = ready_v[sel];
            tick();
            if (rdy) extra++;
            fin = done_v[sel];
        end
        check("done_seen", 32'(fin), 32'd1);
        check("extra_words", 32'(extra), 32'd0);
        check("shift_total", 32'(shifts), 32'(chain_len[sel]));
        check("done_latency", 32'(cyc - last_shift_cyc), 32'd1);
        check("done_isol", 32'(isol_v[sel]), 32'd1);
        check("done_busy", 32'(busy_v[sel]), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check("done_ready", 32'(ready_v[sel]), 32'd0);
        check("done_hold_head", 32'(head_v[sel]), 32'(exp_head));
        check("done_sticky", 32'(done_v[sel]), 32'd1);
        valid_v[sel] = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        start_v = '0;
        valid_v = '0;
        wdata = '0;
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("reset_outputs", 32'({ready_v, head_v, se_v, busy_v, done_v, isol_v}), 32'd0);
        check("reset_state", 32'(u_a.state_q), 32'(IDLE));

        // Back-to-back words, last word truncated to two bits.
        sel = 0;
        begin_load();
        send_word(8'h0A, 1'b0);
        send_word(8'h05, 1'b0);
        send_word(8'h03, 1'b0);
        finish_load(1'b1);

        // Backpressure between words, restarted from DONE.
        begin_load();
        send_word(8'h0A, 1'b0);
        gap(5);
        send_word(8'h05, 1'b0);
        gap(5);
        send_word(8'h03, 1'b0);
        finish_load(1'b1);

        // Exact multiple of word width; start during SHIFT ignored.
        sel = 1;
        begin_load();
        send_word(8'h0F, 1'b1);
        send_word(8'h00, 1'b0);
        finish_load(1'b0);
        begin_load();
        send_word(8'h00, 1'b0);
        send_word(8'h0F, 1'b0);
        finish_load(1'b1);

        // Single-bit chain.
        sel = 2;
        begin_load();
        send_word(8'h81, 1'b0);
        finish_load(1'b1);

        // Reset in the middle of a word.
        sel = 0;
        begin_load();
        send_word(8'h0A, 1'b0);
        tick();
        tick();
        check("pre_reset_shifts", 32'(shifts), 32'd3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_q.delete();
        check("mid_reset_outputs",
              32'({ready_v[0], head_v[0], se_v[0], busy_v[0], done_v[0], isol_v[0]}), 32'd0);
        check("mid_reset_state", 32'(u_a.state_q), 32'(IDLE));
        valid_v[0] = 1'b1;
        repeat (3) tick();
        check("post_reset_ready", 32'(ready_v[0]), 32'd0);
        check("post_reset_se", 32'(se_v[0]), 32'd0);
        check("post_reset_busy", 32'(busy_v[0]), 32'd0);
        check("post_reset_isol", 32'(isol_v[0]), 32'd0);
        valid_v[0] = 1'b0;

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
